// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped peripheral page beside DataMem on the CPU data bus.
// Holds a reload timer that raises a level interrupt, plus LED, switch, 7-segment (digi)
// and a free-running systick counter.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   rd      read strobe (MemRd)
//   wr      write strobe (MemWr), sampled at rising clk
//   addr    byte address; addr[1:0] ignored
//   wdata   write data
//   rdata   combinational read data, 0 when not selected so it can be ORed with DataMem
//   switch  board switches, asynchronous to clk
//   led     LED register
//   digi    7-segment register ([11:8] anode select, [7:0] segments)
//   irqout  timer interrupt request, level
module peripheral_bus #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned SW_W      = 8,
  parameter int unsigned DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  // Word offsets within the page (addr[4:2])
  localparam logic [2:0] RegTh      = 3'd0;
  localparam logic [2:0] RegTl      = 3'd1;
  localparam logic [2:0] RegTcon    = 3'd2;
  localparam logic [2:0] RegLed     = 3'd3;
  localparam logic [2:0] RegSwitch  = 3'd4;
  localparam logic [2:0] RegDigi    = 3'd5;
  localparam logic [2:0] RegSystick = 3'd6;

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [31:0]       systick_q, systick_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

  logic       hit;
  logic [2:0] idx;
  logic       we_th, we_tl, we_tcon, we_led, we_digi;
  logic       overflow;

  assign hit = (addr[31:5] == BASE_ADDR[31:5]);
  assign idx = addr[4:2];

  assign we_th   = wr && hit && (idx == RegTh);
  assign we_tl   = wr && hit && (idx == RegTl);
  assign we_tcon = wr && hit && (idx == RegTcon);
  assign we_led  = wr && hit && (idx == RegLed);
  assign we_digi = wr && hit && (idx == RegDigi);

  assign overflow = tcon_q[0] && (tl_q == 32'hFFFFFFFF);

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    if (we_th) th_d = wdata;

    if (tcon_q[0]) tl_d = overflow ? th_q : tl_q + 32'd1;
    // CPU write takes priority over count/reload
    if (we_tl) tl_d = wdata;

    if (we_tcon) tcon_d = wdata[2:0];
    // Hardware status set wins over a same-cycle software clear
    if (overflow && tcon_q[1]) tcon_d[2] = 1'b1;

    if (we_led)  led_d  = wdata[LED_W-1:0];
    if (we_digi) digi_d = wdata[DIGI_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Reads see pre-edge state, so a same-cycle write returns the old value
  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      unique case (idx)
        RegTh:      rdata = th_q;
        RegTl:      rdata = tl_q;
        RegTcon:    rdata[2:0] = tcon_q;
        RegLed:     rdata[LED_W-1:0] = led_q;
        RegSwitch:  rdata[SW_W-1:0] = sw_sync_q;
        RegDigi:    rdata[DIGI_W-1:0] = digi_q;
        RegSystick: rdata = systick_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_peripheral_bus.sv
// Testbench for peripheral_bus: scenario tasks push expected values to a scoreboard queue
// as stimulus is driven, push observations as they are sampled, then drain and compare.
module tb_peripheral_bus;

  localparam logic [31:0] Base = 32'h40000000;
  localparam logic [31:0] ATh = Base + 32'h00;
  localparam logic [31:0] ATl = Base + 32'h04;
  localparam logic [31:0] ATcon = Base + 32'h08;
  localparam logic [31:0] ALed = Base + 32'h0C;
  localparam logic [31:0] ASw = Base + 32'h10;
  localparam logic [31:0] ADigi = Base + 32'h14;
  localparam logic [31:0] ASys = Base + 32'h18;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  string       name_q[$];
  logic [31:0] e, g, rv, t0;
  string       n;

  always #5 clk = ~clk;

  peripheral_bus dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch(sw), .led(led), .digi(digi), .irqout(irqout)
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    rd = 1'b0;
  endtask

  task automatic expect_val(input string nm, input logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic test_reset;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sw = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_val("rst_led", 32'h0);     expect_val("rst_digi", 32'h0);
    expect_val("rst_irq", 32'h0);     expect_val("rst_tcon", 32'h0);
    expect_val("rst_systick", 32'h0);
    #1 got_q.push_back(32'(led));
    got_q.push_back(32'(digi));
    got_q.push_back(32'(irqout));
    rd = 1'b1; addr = ATcon;
    #1 got_q.push_back(rdata);
    addr = ASys;
    #1 got_q.push_back(rdata);
    rd = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_timer_irq;
    bus_write(ATh, 32'hFFFFFFFD);
    bus_write(ATl, 32'hFFFFFFFD);
    bus_write(ATcon, 32'h3);
    expect_val("tl_e0", 32'hFFFFFFFD); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("tl_e1", 32'hFFFFFFFE); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("tl_e2", 32'hFFFFFFFF); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("tl_reload", 32'hFFFFFFFD); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("irq_set", 32'h1); got_q.push_back(32'(irqout));
    expect_val("tcon_7", 32'h7); bus_read(ATcon, rv); got_q.push_back(rv);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_irq_clear;
    bus_write(ATl, 32'd100);
    bus_write(ATcon, 32'h3);
    expect_val("irq_cleared", 32'h0); got_q.push_back(32'(irqout));
    expect_val("tl_count0", 32'd101); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("tl_count1", 32'd102); bus_read(ATl, rv); got_q.push_back(rv);
    // Overflow with irq disabled: reload only
    bus_write(ATl, 32'hFFFFFFFE);
    bus_write(ATcon, 32'h1);
    expect_val("tl_pre_ovf", 32'hFFFFFFFF); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("tl_reload_noirq", 32'hFFFFFFFD); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("tcon_noirq", 32'h1); bus_read(ATcon, rv); got_q.push_back(rv);
    expect_val("irq_off", 32'h0); got_q.push_back(32'(irqout));
    // Software clear in the overflow cycle loses to the hardware set
    bus_write(ATcon, 32'h3);
    bus_write(ATl, 32'hFFFFFFFF);
    bus_write(ATcon, 32'h3);
    expect_val("tl_hw_wins", 32'hFFFFFFFD); bus_read(ATl, rv); got_q.push_back(rv);
    expect_val("tcon_hw_wins", 32'h7); bus_read(ATcon, rv); got_q.push_back(rv);
    expect_val("irq_hw_wins", 32'h1); got_q.push_back(32'(irqout));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_led_digi;
    bus_write(ALed, 32'h123456A5);
    expect_val("led_port", 32'hA5); got_q.push_back(32'(led));
    expect_val("led_read", 32'hA5); bus_read(ALed, rv); got_q.push_back(rv);
    bus_write(ADigi, 32'hFFFF0F3F);
    expect_val("digi_port", 32'hF3F); got_q.push_back(32'(digi));
    expect_val("digi_read", 32'hF3F); bus_read(ADigi, rv); got_q.push_back(rv);
    // Read and write in the same cycle returns the old value
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = ALed; wdata = 32'h0000005A;
    expect_val("rw_same_cycle", 32'hA5);
    #1 got_q.push_back(rdata);
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
    expect_val("led_after_rw", 32'h5A); got_q.push_back(32'(led));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_switch;
    @(negedge clk);
    sw = 8'h3C;
    rd = 1'b1; addr = ASw;
    expect_val("sw_edge0", 32'h0);  #1 got_q.push_back(rdata);
    @(negedge clk);
    expect_val("sw_edge1", 32'h0);  #1 got_q.push_back(rdata);
    @(negedge clk);
    expect_val("sw_edge2", 32'h3C); #1 got_q.push_back(rdata);
    rd = 1'b0;
    bus_write(ASw, 32'h0);
    expect_val("sw_ro", 32'h3C); bus_read(ASw, rv); got_q.push_back(rv);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_decode_systick;
    expect_val("rd_1c", 32'h0); bus_read(Base + 32'h1C, rv); got_q.push_back(rv);
    expect_val("rd_offpage", 32'h0); bus_read(32'h40000100, rv); got_q.push_back(rv);
    @(negedge clk);
    rd = 1'b0; addr = ALed;
    expect_val("rd_low", 32'h0); #1 got_q.push_back(rdata);
    bus_write(Base + 32'h1C, 32'hFFFFFFFF);
    expect_val("wr_1c_led", 32'h5A); got_q.push_back(32'(led));
    @(negedge clk);
    rd = 1'b1; addr = ASys;
    #1 t0 = rdata;
    repeat (7) @(negedge clk);
    expect_val("systick_delta", 32'd7);
    #1 got_q.push_back(rdata - t0);
    rd = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #1;
    expect_val("irq_before_rst", 32'h1); got_q.push_back(32'(irqout));
    reset = 1'b1;
    #1;
    expect_val("arst_led", 32'h0);  got_q.push_back(32'(led));
    expect_val("arst_digi", 32'h0); got_q.push_back(32'(digi));
    expect_val("arst_irq", 32'h0);  got_q.push_back(32'(irqout));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd = 1'b1;
    addr = ATl;   expect_val("arst_tl", 32'h0);      #1 got_q.push_back(rdata);
    addr = ATh;   expect_val("arst_th", 32'h0);      #1 got_q.push_back(rdata);
    addr = ATcon; expect_val("arst_tcon", 32'h0);    #1 got_q.push_back(rdata);
    addr = ASys;  expect_val("arst_systick", 32'h0); #1 got_q.push_back(rdata);
    rd = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_irq_clear();
    test_led_digi();
    test_switch();
    test_decode_systick();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
